// File: rtl/bcd_scan_sequencer.sv
// bcd_scan_sequencer
//
// Converts a packed BCD word of NDIG digits into active-low 7-segment
// patterns. A single shared decoder walks the digits one per clock, from the
// most significant digit down. Each result lands in a shadow register, and
// the whole display is then updated in one commit cycle, so the HEX
// displays never show a mix of old and new digits.
//
// Ports
//   V_CLK   : system clock, rising edge
//   V_RST   : synchronous reset, active-high, aborts any running conversion
//   V_BCD   : packed BCD input, digit k = V_BCD[4k+3:4k]
//   V_LOAD  : start request, accepted only while V_BUSY is low
//   V_LZB   : leading-zero blanking enable, sampled together with V_LOAD
//   V_BUSY  : high from the load edge until the commit edge
//   V_DONE  : one-cycle pulse, high while the freshly committed value is shown
//   V_ERR   : set if the last committed value contained a digit 10..15
//   G_HEX   : segment patterns, digit k = G_HEX[7k+6:7k], bit 7k+6 = seg a

module bcd_scan_sequencer #(
  parameter int NDIG = 4
) (
  input  logic              V_CLK,
  input  logic              V_RST,
  input  logic [4*NDIG-1:0] V_BCD,
  input  logic              V_LOAD,
  input  logic              V_LZB,
  output logic              V_BUSY,
  output logic              V_DONE,
  output logic              V_ERR,
  output logic [7*NDIG-1:0] G_HEX
);

  // Index width has to stay at least one bit wide for the single-digit case.
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NDIG - 1);
  localparam logic [6:0] BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    COMMIT
  } state_t;

  state_t          state;
  state_t          state_next;

  logic [3:0]      bcd_q   [NDIG];
  logic [6:0]      shadow  [NDIG];
  logic [6:0]      hex_q   [NDIG];
  logic [IW-1:0]   idx;
  logic            lz_active;
  logic            err_acc;
  logic            err_q;
  logic            done_q;

  logic [3:0]      nibble;
  logic [6:0]      seg_dec;
  logic            nib_bad;
  logic            blank_lz;
  logic [6:0]      seg_store;

  // The one shared decoder. It always looks at the captured digit that the
  // scan index points at. Codes 10..15 decode to blank and are flagged.
  always_comb begin
    nibble  = bcd_q[idx];
    seg_dec = BLANK;
    nib_bad = 1'b0;
    case (nibble)
      4'd0:    seg_dec = 7'b0000001;
      4'd1:    seg_dec = 7'b1001111;
      4'd2:    seg_dec = 7'b0010010;
      4'd3:    seg_dec = 7'b0000110;
      4'd4:    seg_dec = 7'b1001100;
      4'd5:    seg_dec = 7'b0100100;
      4'd6:    seg_dec = 7'b0100000;
      4'd7:    seg_dec = 7'b0001111;
      4'd8:    seg_dec = 7'b0000000;
      4'd9:    seg_dec = 7'b0000100;
      default: begin
        seg_dec = BLANK;
        nib_bad = 1'b1;
      end
    endcase
  end

  // Blanking only holds while every more significant digit seen so far was
  // zero. Digit 0 is exempt so that a value of zero still shows "0". An
  // invalid code is nonzero, so it ends blanking like a real digit does.
  always_comb begin
    blank_lz  = lz_active && (nibble == 4'd0) && (idx != '0);
    seg_store = (blank_lz || nib_bad) ? BLANK : seg_dec;
  end

  // Next-state logic and the busy flag. Busy covers both SCAN and COMMIT,
  // so a load request that arrives during the commit cycle is dropped.
  always_comb begin
    state_next = state;
    V_BUSY     = 1'b0;
    case (state)
      IDLE: begin
        if (V_LOAD) begin
          state_next = SCAN;
        end
      end
      SCAN: begin
        V_BUSY = 1'b1;
        if (idx == '0) begin
          state_next = COMMIT;
        end
      end
      COMMIT: begin
        V_BUSY     = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register plus datapath. Reset wipes the shadow registers as well
  // as the visible display, so an aborted scan leaves nothing behind.
  // V_DONE is registered from the COMMIT state, so it rises on the same
  // edge that loads the new G_HEX value.
  always_ff @(posedge V_CLK) begin
    if (V_RST) begin
      state     <= IDLE;
      idx       <= '0;
      lz_active <= 1'b0;
      err_acc   <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      for (int k = 0; k < NDIG; k++) begin
        bcd_q[k]  <= 4'd0;
        shadow[k] <= BLANK;
        hex_q[k]  <= BLANK;
      end
    end else begin
      state  <= state_next;
      done_q <= (state == COMMIT);
      case (state)
        IDLE: begin
          if (V_LOAD) begin
            for (int k = 0; k < NDIG; k++) begin
              bcd_q[k] <= V_BCD[4*k +: 4];
            end
            idx       <= LAST_IDX;
            lz_active <= V_LZB;
            err_acc   <= 1'b0;
          end
        end
        SCAN: begin
          shadow[idx] <= seg_store;
          idx         <= idx - IW'(1);
          if (!blank_lz) begin
            lz_active <= 1'b0;
          end
          if (nib_bad) begin
            err_acc <= 1'b1;
          end
        end
        COMMIT: begin
          for (int k = 0; k < NDIG; k++) begin
            hex_q[k] <= shadow[k];
          end
          err_q <= err_acc;
        end
        default: begin
        end
      endcase
    end
  end

  // Pack the committed digits onto the output bus.
  always_comb begin
    G_HEX = '0;
    for (int k = 0; k < NDIG; k++) begin
      G_HEX[7*k +: 7] = hex_q[k];
    end
  end

  assign V_DONE = done_q;
  assign V_ERR  = err_q;

endmodule

// File: tb/tb_bcd_scan_sequencer.sv
// tb_bcd_scan_sequencer
//
// Directed and random conversions for a four-digit bcd_scan_sequencer. The
// expected segment patterns come from a reference model that works on whole
// values. In that model, a digit is blanked when every digit from it upward
// is zero. The bench also checks busy, done and display-hold timing around
// each conversion.

module tb_bcd_scan_sequencer;

  localparam int NDIG = 4;

  logic              V_CLK = 1'b0;
  logic              V_RST;
  logic [4*NDIG-1:0] V_BCD;
  logic              V_LOAD;
  logic              V_LZB;
  logic              V_BUSY;
  logic              V_DONE;
  logic              V_ERR;
  logic [7*NDIG-1:0] G_HEX;

  int total = 0;
  int bad   = 0;
  logic [7*NDIG-1:0] prevHex;

  bcd_scan_sequencer #(.NDIG(NDIG)) dut (
    .V_CLK  (V_CLK),
    .V_RST  (V_RST),
    .V_BCD  (V_BCD),
    .V_LOAD (V_LOAD),
    .V_LZB  (V_LZB),
    .V_BUSY (V_BUSY),
    .V_DONE (V_DONE),
    .V_ERR  (V_ERR),
    .G_HEX  (G_HEX)
  );

  // Free-running 10 ns clock.
  always #5 V_CLK = ~V_CLK;

  // Decoding of one valid decimal digit to its active-low abcdefg pattern.
  function automatic logic [6:0] segOf(input int d);
    case (d)
      0:       return 7'b0000001;
      1:       return 7'b1001111;
      2:       return 7'b0010010;
      3:       return 7'b0000110;
      4:       return 7'b1001100;
      5:       return 7'b0100100;
      6:       return 7'b0100000;
      7:       return 7'b0001111;
      8:       return 7'b0000000;
      9:       return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  // Whole-display model. A digit goes blank if blanking is on, it is not
  // digit 0, and it and every digit above it are zero. Otherwise it shows
  // its decoded pattern, or blank when the code is 10..15.
  function automatic logic [7*NDIG-1:0] modelHex(input logic [4*NDIG-1:0] v, input logic lzb);
    int d [NDIG];
    logic [7*NDIG-1:0] r;
    r = '0;
    for (int k = 0; k < NDIG; k++) d[k] = int'((v >> (4*k)) & 16'hF);
    for (int k = 0; k < NDIG; k++) begin
      bit upperZero;
      upperZero = 1'b1;
      for (int j = k; j < NDIG; j++) if (d[j] != 0) upperZero = 1'b0;
      if (lzb && k > 0 && upperZero) r[7*k +: 7] = 7'b1111111;
      else r[7*k +: 7] = segOf(d[k]);
    end
    return r;
  endfunction

  function automatic logic modelErr(input logic [4*NDIG-1:0] v);
    for (int k = 0; k < NDIG; k++) if (((v >> (4*k)) & 16'hF) > 9) return 1'b1;
    return 1'b0;
  endfunction

  task automatic tick;
    @(posedge V_CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
      else begin
        bad++;
        $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  // One full conversion, checked at every edge. A nonzero intrudeAt fires a
  // second load of 5555 before SCAN edge t+intrudeAt. That load must be
  // ignored.
  task automatic applyStimulus(input logic [4*NDIG-1:0] value, input logic lzb, input int intrudeAt);
    logic [7*NDIG-1:0] expHex;
    logic expErr;
    expHex = modelHex(value, lzb);
    expErr = modelErr(value);
    V_BCD  = value;
    V_LZB  = lzb;
    V_LOAD = 1'b1;
    tick();
    V_LOAD = 1'b0;
    V_BCD  = 16'($urandom);
    V_LZB  = ~lzb;
    checkOutput("busyAfterLoad", 32'(V_BUSY), 32'd1);
    checkOutput("doneAfterLoad", 32'(V_DONE), 32'd0);
    for (int i = 1; i <= NDIG; i++) begin
      if (i == intrudeAt) begin
        V_LOAD = 1'b1;
        V_BCD  = 16'h5555;
      end
      tick();
      V_LOAD = 1'b0;
      checkOutput("busyScan", 32'(V_BUSY), 32'd1);
      checkOutput("doneScan", 32'(V_DONE), 32'd0);
      checkOutput("hexHeld", 32'(G_HEX), 32'(prevHex));
    end
    tick();
    checkOutput("hexCommit", 32'(G_HEX), 32'(expHex));
    checkOutput("errCommit", 32'(V_ERR), 32'(expErr));
    checkOutput("doneCommit", 32'(V_DONE), 32'd1);
    checkOutput("busyCommit", 32'(V_BUSY), 32'd0);
    prevHex = expHex;
    tick();
    checkOutput("donePulse", 32'(V_DONE), 32'd0);
    checkOutput("hexAfter", 32'(G_HEX), 32'(expHex));
  endtask

  initial begin
    V_RST   = 1'b1;
    V_LOAD  = 1'b0;
    V_LZB   = 1'b0;
    V_BCD   = '0;
    prevHex = '1;

    // Reset held for two edges, then the idle outputs are checked.
    tick();
    tick();
    V_RST = 1'b0;
    checkOutput("rstHex", 32'(G_HEX), 32'h0FFFFFFF);
    checkOutput("rstBusy", 32'(V_BUSY), 32'd0);
    checkOutput("rstDone", 32'(V_DONE), 32'd0);
    checkOutput("rstErr", 32'(V_ERR), 32'd0);
    tick();

    // Directed cases. 1234 is also checked against a hand-written pattern
    // to anchor the model.
    applyStimulus(16'h1234, 1'b0, 0);
    checkOutput("hex1234Lit", 32'(G_HEX), 32'({7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}));
    applyStimulus(16'h0070, 1'b1, 0);
    checkOutput("hex0070Lit", 32'(G_HEX), 32'({7'b1111111, 7'b1111111, 7'b0001111, 7'b0000001}));
    applyStimulus(16'h0000, 1'b1, 0);
    applyStimulus(16'h0000, 1'b0, 0);
    applyStimulus(16'h9A05, 1'b1, 0);
    checkOutput("hex9A05Lit", 32'(G_HEX), 32'({7'b0000100, 7'b1111111, 7'b0000001, 7'b0100100}));
    applyStimulus(16'h0001, 1'b0, 0);
    applyStimulus(16'h1234, 1'b0, 2);
    applyStimulus(16'h9A05, 1'b1, 0);

    // Reset on edge t+3 of a conversion. Nothing may be committed.
    V_BCD  = 16'h1234;
    V_LZB  = 1'b0;
    V_LOAD = 1'b1;
    tick();
    V_LOAD = 1'b0;
    tick();
    tick();
    V_RST = 1'b1;
    tick();
    V_RST = 1'b0;
    checkOutput("abortHex", 32'(G_HEX), 32'h0FFFFFFF);
    checkOutput("abortBusy", 32'(V_BUSY), 32'd0);
    checkOutput("abortDone", 32'(V_DONE), 32'd0);
    checkOutput("abortErr", 32'(V_ERR), 32'd0);
    for (int i = 0; i < NDIG + 2; i++) begin
      tick();
      checkOutput("abortNoDone", 32'(V_DONE), 32'd0);
      checkOutput("abortHexHeld", 32'(G_HEX), 32'h0FFFFFFF);
    end
    prevHex = '1;

    // Random values. Zero digits are weighted up so that blanking runs of
    // several lengths occur.
    for (int n = 0; n < 40; n++) begin
      logic [4*NDIG-1:0] v;
      v = '0;
      for (int k = 0; k < NDIG; k++) begin
        if ($urandom_range(0, 2) != 0) v[4*k +: 4] = 4'($urandom_range(0, 15));
      end
      applyStimulus(v, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, NDIG)) : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
